// File: rtl/ram_arbiter_if.sv
// ---------------------------------------------------------------------------
// ram_arbiter_if
// Bundles every bus signal around the RAM arbiter: the CPU request port, the
// VGA framebuffer read port, the RAM controller port and the debug owner flag.
//
// Modports:
//   slave  - the arbiter's view. It serves the CPU and VGA requesters, drives
//            the RAM controller request side and reports the current owner.
//   master - the surroundings (core, vgactlr, ramctlr). It drives the
//            requests and the RAM controller responses.
//
// Signal summary:
//   cpu_req/cpu_we/cpu_addr/cpu_wdata  CPU request, held until cpu_ack
//   cpu_rdata/cpu_ack/cpu_err          CPU completion (err qualifies ack)
//   vga_req/vga_addr                   VGA read request, held until vga_ack
//   vga_rdata/vga_ack/vga_err          VGA completion (err qualifies ack)
//   mem_req/mem_we/mem_addr/mem_wdata  request to ramctlr
//   mem_rdata/mem_ack                  response from ramctlr
//   owner                              current/last grant, 0 = CPU, 1 = VGA
// ---------------------------------------------------------------------------
interface ram_arbiter_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_ack;
    logic        cpu_err;

    logic        vga_req;
    logic [31:0] vga_addr;
    logic [31:0] vga_rdata;
    logic        vga_ack;
    logic        vga_err;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    logic        owner;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack, cpu_err,
        input  vga_req, vga_addr,
        output vga_rdata, vga_ack, vga_err,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack,
        output owner
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack, cpu_err,
        output vga_req, vga_addr,
        input  vga_rdata, vga_ack, vga_err,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack,
        input  owner
    );
endinterface

// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// ram_arbiter
// Shares the single RAM controller port between the CPU core (read/write)
// and the VGA controller (framebuffer reads). VGA wins by default because
// its display timing is real-time; a saturating starvation counter hands
// the port to a waiting CPU after CPU_MAX_WAIT lost arbitrations. A
// watchdog aborts a transaction whose mem_ack never arrives and returns
// ERR_DATA with the requester's err flag set.
//
// Ports:
//   i_clk    system clock
//   i_rst_n  asynchronous active-low reset
//   io_bus   ram_arbiter_if.slave - CPU, VGA, RAM controller and owner
//
// Parameters:
//   CPU_MAX_WAIT  lost arbitration cycles before the CPU beats VGA (1..15)
//   TIMEOUT       BUSY cycles without mem_ack before abort (2..255)
//   ERR_DATA      read data returned on an aborted transaction
// ---------------------------------------------------------------------------
module ram_arbiter #(
    parameter int unsigned CPU_MAX_WAIT = 8,
    parameter int unsigned TIMEOUT      = 64,
    parameter logic [31:0] ERR_DATA     = 32'hDEADBEEF
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    ram_arbiter_if.slave  io_bus
);

    localparam logic [3:0] LP_MAX_WAIT  = 4'(CPU_MAX_WAIT);
    localparam logic [7:0] LP_TOUT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cpu_wait;
    logic [7:0]  r_tout;

    logic        r_mem_req;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic        r_owner;

    logic [31:0] r_cpu_rdata;
    logic        r_cpu_ack;
    logic        r_cpu_err;
    logic [31:0] r_vga_rdata;
    logic        r_vga_ack;
    logic        r_vga_err;

    logic        w_cpu_starved;
    logic        w_grant_vga;
    logic        w_grant_cpu;

    // Arbitration decision, only acted upon in IDLE. VGA wins unless the CPU
    // has already lost CPU_MAX_WAIT times in a row.
    assign w_cpu_starved = io_bus.cpu_req && (r_cpu_wait == LP_MAX_WAIT);
    assign w_grant_vga   = io_bus.vga_req && !w_cpu_starved;
    assign w_grant_cpu   = !w_grant_vga && io_bus.cpu_req;

    // Main FSM: IDLE arbitrates and latches the winner's request, BUSY waits
    // for mem_ack or the watchdog, ACK pulses the owner's ack for one cycle.
    // Every output is a register updated here.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_cpu_wait  <= 4'd0;
            r_tout      <= 8'd0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_owner     <= 1'b0;
            r_cpu_rdata <= 32'd0;
            r_cpu_ack   <= 1'b0;
            r_cpu_err   <= 1'b0;
            r_vga_rdata <= 32'd0;
            r_vga_ack   <= 1'b0;
            r_vga_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_vga) begin
                        r_mem_addr  <= io_bus.vga_addr;
                        r_mem_we    <= 1'b0;
                        r_mem_wdata <= 32'd0;
                        r_owner     <= 1'b1;
                        r_mem_req   <= 1'b1;
                        r_vga_err   <= 1'b0;
                        r_tout      <= 8'd0;
                        r_state     <= BUSY;
                        // A CPU that loses here counts one more lost round,
                        // saturating so it can never wrap back to zero.
                        if (!io_bus.cpu_req) begin
                            r_cpu_wait <= 4'd0;
                        end else if (r_cpu_wait != LP_MAX_WAIT) begin
                            r_cpu_wait <= r_cpu_wait + 4'd1;
                        end
                    end else if (w_grant_cpu) begin
                        r_mem_addr  <= io_bus.cpu_addr;
                        r_mem_we    <= io_bus.cpu_we;
                        r_mem_wdata <= io_bus.cpu_wdata;
                        r_owner     <= 1'b0;
                        r_mem_req   <= 1'b1;
                        r_cpu_err   <= 1'b0;
                        r_cpu_wait  <= 4'd0;
                        r_tout      <= 8'd0;
                        r_state     <= BUSY;
                    end else begin
                        r_cpu_wait <= 4'd0;
                    end
                end

                BUSY: begin
                    if (io_bus.mem_ack) begin
                        r_mem_req <= 1'b0;
                        if (r_owner) begin
                            r_vga_rdata <= io_bus.mem_rdata;
                            r_vga_ack   <= 1'b1;
                        end else begin
                            r_cpu_rdata <= io_bus.mem_rdata;
                            r_cpu_ack   <= 1'b1;
                        end
                        r_state <= ACK;
                    end else if (r_tout == LP_TOUT_LAST) begin
                        // Watchdog abort: complete the transaction with
                        // ERR_DATA so the requester is never left hanging.
                        r_mem_req <= 1'b0;
                        if (r_owner) begin
                            r_vga_rdata <= ERR_DATA;
                            r_vga_err   <= 1'b1;
                            r_vga_ack   <= 1'b1;
                        end else begin
                            r_cpu_rdata <= ERR_DATA;
                            r_cpu_err   <= 1'b1;
                            r_cpu_ack   <= 1'b1;
                        end
                        r_state <= ACK;
                    end else begin
                        r_tout <= r_tout + 8'd1;
                    end
                end

                ACK: begin
                    // The requester drops req on the edge it sees ack, so no
                    // arbitration here avoids re-granting a stale request.
                    r_cpu_ack <= 1'b0;
                    r_vga_ack <= 1'b0;
                    r_tout    <= 8'd0;
                    r_state   <= IDLE;
                end

                default: begin
                    r_mem_req <= 1'b0;
                    r_cpu_ack <= 1'b0;
                    r_vga_ack <= 1'b0;
                    r_tout    <= 8'd0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign io_bus.mem_req   = r_mem_req;
    assign io_bus.mem_we    = r_mem_we;
    assign io_bus.mem_addr  = r_mem_addr;
    assign io_bus.mem_wdata = r_mem_wdata;
    assign io_bus.owner     = r_owner;
    assign io_bus.cpu_rdata = r_cpu_rdata;
    assign io_bus.cpu_ack   = r_cpu_ack;
    assign io_bus.cpu_err   = r_cpu_err;
    assign io_bus.vga_rdata = r_vga_rdata;
    assign io_bus.vga_ack   = r_vga_ack;
    assign io_bus.vga_err   = r_vga_err;

endmodule

// File: tb/tb_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_arbiter
// Directed testbench for ram_arbiter: reset state, CPU write, delayed VGA
// read, starvation hand-over, watchdog abort with a late mem_ack, error
// clearing on the next grant, and an asynchronous reset in the middle of a
// transaction. Inputs change 1 time unit after the rising edge and outputs
// are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_ram_arbiter;

    logic clk = 1'b0;
    logic rstN;
    int   checkCount = 0;
    int   passCount  = 0;

    ram_arbiter_if bus ();

    ram_arbiter #(
        .CPU_MAX_WAIT (8),
        .TIMEOUT      (64),
        .ERR_DATA     (32'hDEADBEEF)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rstN),
        .io_bus  (bus)
    );

    // Free-running clock with rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive every requester and RAM controller input in one call.
    task automatic applyStimulus(input logic cpuReq, input logic cpuWe,
                                 input logic [31:0] cpuAddr, input logic [31:0] cpuWdata,
                                 input logic vgaReq, input logic [31:0] vgaAddr,
                                 input logic memAck, input logic [31:0] memRdata);
        bus.cpu_req   = cpuReq;
        bus.cpu_we    = cpuWe;
        bus.cpu_addr  = cpuAddr;
        bus.cpu_wdata = cpuWdata;
        bus.vga_req   = vgaReq;
        bus.vga_addr  = vgaAddr;
        bus.mem_ack   = memAck;
        bus.mem_rdata = memRdata;
    endtask

    // One comparison of a DUT output against a hand-computed value.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    endtask

    // Hard time limit so the run always ends on its own.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        logic expOwner;

        // ---------------- reset state ----------------
        rstN = 1'b1;
        applyStimulus(0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0);
        #2 rstN = 1'b0;
        tick();
        tick();
        checkOutput("rst_mem_req",   32'(bus.mem_req),   32'h0);
        checkOutput("rst_cpu_ack",   32'(bus.cpu_ack),   32'h0);
        checkOutput("rst_vga_ack",   32'(bus.vga_ack),   32'h0);
        checkOutput("rst_owner",     32'(bus.owner),     32'h0);
        checkOutput("rst_cpu_rdata", bus.cpu_rdata,      32'h0);
        checkOutput("rst_vga_rdata", bus.vga_rdata,      32'h0);
        rstN = 1'b1;
        tick();

        // ---------------- CPU write, mem_ack in first BUSY cycle ----------------
        applyStimulus(1, 1, 32'h100, 32'h12345678, 0, 32'h0, 0, 32'h0);
        tick();
        checkOutput("cpuwr_mem_req",   32'(bus.mem_req), 32'h1);
        checkOutput("cpuwr_mem_we",    32'(bus.mem_we),  32'h1);
        checkOutput("cpuwr_mem_addr",  bus.mem_addr,     32'h100);
        checkOutput("cpuwr_mem_wdata", bus.mem_wdata,    32'h12345678);
        checkOutput("cpuwr_owner",     32'(bus.owner),   32'h0);
        checkOutput("cpuwr_ack_early", 32'(bus.cpu_ack), 32'h0);
        bus.mem_ack = 1'b1;
        tick();
        checkOutput("cpuwr_cpu_ack",   32'(bus.cpu_ack), 32'h1);
        checkOutput("cpuwr_cpu_err",   32'(bus.cpu_err), 32'h0);
        checkOutput("cpuwr_vga_ack",   32'(bus.vga_ack), 32'h0);
        checkOutput("cpuwr_mem_req_lo", 32'(bus.mem_req), 32'h0);
        applyStimulus(0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0);
        tick();
        checkOutput("cpuwr_ack_pulse", 32'(bus.cpu_ack), 32'h0);
        tick();

        // ---------------- VGA read with 3-cycle mem_ack delay ----------------
        applyStimulus(0, 0, 32'h0, 32'h0, 1, 32'h8000, 0, 32'hA5A5A5A5);
        tick();
        checkOutput("vga_mem_req",  32'(bus.mem_req), 32'h1);
        checkOutput("vga_mem_addr", bus.mem_addr,     32'h8000);
        checkOutput("vga_mem_we",   32'(bus.mem_we),  32'h0);
        checkOutput("vga_owner",    32'(bus.owner),   32'h1);
        tick();
        tick();
        checkOutput("vga_still_busy", 32'(bus.mem_req), 32'h1);
        checkOutput("vga_no_ack_yet", 32'(bus.vga_ack), 32'h0);
        bus.mem_ack = 1'b1;
        tick();
        checkOutput("vga_ack",       32'(bus.vga_ack), 32'h1);
        checkOutput("vga_rdata",     bus.vga_rdata,    32'hA5A5A5A5);
        checkOutput("vga_err",       32'(bus.vga_err), 32'h0);
        checkOutput("vga_cpu_ack",   32'(bus.cpu_ack), 32'h0);
        applyStimulus(0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0);
        tick();
        checkOutput("vga_ack_pulse",  32'(bus.vga_ack), 32'h0);
        checkOutput("vga_rdata_hold", bus.vga_rdata,    32'hA5A5A5A5);
        tick();

        // ---------------- starvation: VGA wins 8, CPU gets the 9th ----------------
        // The 10th grant returns to VGA, showing the wait counter was cleared.
        applyStimulus(1, 0, 32'h200, 32'h0, 1, 32'h9000, 0, 32'h11112222);
        for (int g = 1; g <= 10; g++) begin
            tick();
            expOwner = (g == 9) ? 1'b0 : 1'b1;
            checkOutput($sformatf("starve_owner_%0d", g), 32'(bus.owner), 32'(expOwner));
            checkOutput($sformatf("starve_addr_%0d", g), bus.mem_addr,
                        (g == 9) ? 32'h200 : 32'h9000);
            bus.mem_ack = 1'b1;
            tick();
            checkOutput($sformatf("starve_cpu_ack_%0d", g), 32'(bus.cpu_ack), (g == 9) ? 32'h1 : 32'h0);
            checkOutput($sformatf("starve_vga_ack_%0d", g), 32'(bus.vga_ack), (g == 9) ? 32'h0 : 32'h1);
            bus.mem_ack = 1'b0;
            tick();
        end
        checkOutput("starve_cpu_rdata", bus.cpu_rdata, 32'h11112222);
        applyStimulus(0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0);
        tick();

        // ---------------- watchdog timeout on a CPU read ----------------
        applyStimulus(1, 0, 32'h300, 32'h0, 0, 32'h0, 0, 32'h0);
        tick();
        checkOutput("tout_mem_req", 32'(bus.mem_req), 32'h1);
        checkOutput("tout_owner",   32'(bus.owner),   32'h0);
        for (int i = 1; i <= 63; i++) begin
            tick();
            checkOutput($sformatf("tout_busy_%0d", i), 32'(bus.mem_req), 32'h1);
            checkOutput($sformatf("tout_noack_%0d", i), 32'(bus.cpu_ack), 32'h0);
        end
        tick();
        checkOutput("tout_mem_req_lo", 32'(bus.mem_req), 32'h0);
        checkOutput("tout_cpu_ack",    32'(bus.cpu_ack), 32'h1);
        checkOutput("tout_cpu_err",    32'(bus.cpu_err), 32'h1);
        checkOutput("tout_cpu_rdata",  bus.cpu_rdata,    32'hDEADBEEF);
        // Late mem_ack after the abort must be ignored.
        applyStimulus(0, 0, 32'h0, 32'h0, 0, 32'h0, 1, 32'h77777777);
        for (int i = 1; i <= 3; i++) begin
            tick();
            checkOutput($sformatf("late_mem_req_%0d", i), 32'(bus.mem_req), 32'h0);
            checkOutput($sformatf("late_cpu_ack_%0d", i), 32'(bus.cpu_ack), 32'h0);
            checkOutput($sformatf("late_vga_ack_%0d", i), 32'(bus.vga_ack), 32'h0);
        end
        checkOutput("late_cpu_rdata", bus.cpu_rdata,    32'hDEADBEEF);
        checkOutput("late_cpu_err",   32'(bus.cpu_err), 32'h1);

        // ---------------- next CPU grant clears err ----------------
        applyStimulus(1, 0, 32'h400, 32'h0, 0, 32'h0, 0, 32'hCAFEF00D);
        tick();
        checkOutput("clr_cpu_err",    32'(bus.cpu_err), 32'h0);
        checkOutput("clr_rdata_hold", bus.cpu_rdata,    32'hDEADBEEF);
        bus.mem_ack = 1'b1;
        tick();
        checkOutput("clr_cpu_ack",   32'(bus.cpu_ack), 32'h1);
        checkOutput("clr_cpu_rdata", bus.cpu_rdata,    32'hCAFEF00D);
        applyStimulus(0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0);
        tick();
        tick();

        // ---------------- asynchronous reset while BUSY ----------------
        applyStimulus(1, 1, 32'h500, 32'h55, 0, 32'h0, 0, 32'h0);
        tick();
        checkOutput("rstbusy_mem_req", 32'(bus.mem_req), 32'h1);
        #2 rstN = 1'b0;
        #1;
        checkOutput("rstbusy_mem_req_lo", 32'(bus.mem_req), 32'h0);
        checkOutput("rstbusy_mem_we",     32'(bus.mem_we),  32'h0);
        checkOutput("rstbusy_mem_addr",   bus.mem_addr,     32'h0);
        checkOutput("rstbusy_cpu_rdata",  bus.cpu_rdata,    32'h0);
        applyStimulus(0, 0, 32'h0, 32'h0, 0, 32'h0, 1, 32'h0);
        tick();
        tick();
        checkOutput("rstbusy_no_cpu_ack", 32'(bus.cpu_ack), 32'h0);
        checkOutput("rstbusy_no_vga_ack", 32'(bus.vga_ack), 32'h0);
        rstN = 1'b1;
        applyStimulus(0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0);
        tick();
        applyStimulus(1, 0, 32'h600, 32'h0, 0, 32'h0, 0, 32'h0BADF00D);
        tick();
        checkOutput("post_mem_req",  32'(bus.mem_req), 32'h1);
        checkOutput("post_mem_addr", bus.mem_addr,     32'h600);
        bus.mem_ack = 1'b1;
        tick();
        checkOutput("post_cpu_ack",   32'(bus.cpu_ack), 32'h1);
        checkOutput("post_cpu_err",   32'(bus.cpu_err), 32'h0);
        checkOutput("post_cpu_rdata", bus.cpu_rdata,    32'h0BADF00D);
        applyStimulus(0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0);
        tick();
        checkOutput("post_ack_pulse", 32'(bus.cpu_ack), 32'h0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
